id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised successor to the instruction-decode stage of the 5-stage pipeline.
- Decodes inst_in, reads a built-in register file and sign-extends the immediate.
- Registers all decoded fields into an internal ID/EXE pipeline register with valid, stall and flush control.
- Detects RAW hazards against the EXE and MEM stages and drives stall_out back to IF; counts stall cycles.

Parameters:
XLEN, 32, datapath width (PC, register, immediate width after extension)
REG_ADDR_W, 5, register address width; file holds 2**REG_ADDR_W entries, entry 0 reads as zero
SIGN_EXT, 1, 1 = sign-extend imm16 to XLEN, 0 = zero-extend

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
pc_in  in  XLEN  PC of inst_in
inst_in  in  32  instruction: opcode [31:26], src1 [25:21], src2 [20:16], dest [15:11], imm [15:0] (src/dest fields are the low REG_ADDR_W bits of those slices)
inst_valid  in  1  inst_in holds a real instruction
flush  in  1  taken branch; squash the instruction in ID
wb_write_en  in  1  WB-stage register write
wb_dest  in  REG_ADDR_W  WB write address
wb_value  in  XLEN  WB write data
exe_dest, mem_dest  in  REG_ADDR_W  destinations in EXE and MEM
exe_wb_en, mem_wb_en  in  1  EXE/MEM will write exe_dest/mem_dest
exe_mem_read  in  1  EXE instruction is a load
exe_fwd_value, mem_fwd_value  in  XLEN  EXE/MEM results; used only with FORWARD_EN
stall_out  out  1  combinational; IF must hold PC and inst_in
valid_out  out  1  ID/EXE register holds a real instruction
pc_out  out  XLEN  registered pc_in
wb_en, mem_read, mem_write  out  1  registered control bits
br  out  2  registered branch type
exe_cmd  out  4  registered ALU command
reg1  out  XLEN  registered src1 value
reg2  out  XLEN  registered second ALU operand: immediate if is_imm, else src2 value
st_val  out  XLEN  registered src2 value (store data)
out_dest  out  REG_ADDR_W  registered destination: src2 if is_imm, else dest
stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Decode uses the existing ControlUnit opcode mapping: mem_read, mem_write, wb_en, is_imm, br, exe_cmd.
- Register file:
  - synchronous write on clk when wb_write_en && wb_dest != 0;
  - reads combinational, with write-through: reading wb_dest while it is being written returns wb_value;
  - address 0 always reads 0;
  - rst clears all entries.
- Operands used: src1 always; src2 when !is_imm or mem_write.
- hazard = inst_valid && a used src is nonzero and equals (exe_dest with exe_wb_en) or (mem_dest with mem_wb_en).
- stall_out = hazard && !flush.
- Each clk, ID/EXE register loads:
  - rst: everything 0, including valid_out and stall_cnt.
  - flush (priority over stall): bubble.
  - stall_out: bubble.
  - otherwise: decoded fields; valid_out = inst_valid.
- Bubble: valid_out, wb_en, mem_read, mem_write = 0; br = 0; other data fields don't-care (drive 0).
- Invalid instruction (inst_valid=0): all control bits registered as 0.
- Latency: 1 cycle, inst_in to outputs.
- stall_cnt increments on every cycle stall_out=1; holds at 0xFFFFFFFF.
- rst while stalled: stall_out may stay high combinationally; registered outputs are 0 the next cycle.

Optional Feature:
- Macro FORWARD_EN.
- Defined:
  - stall only for load-use: exe_mem_read && exe_wb_en && exe_dest matches a used nonzero src;
  - otherwise forward, priority EXE (exe_fwd_value) > MEM (mem_fwd_value) > WB write-through > file.
- Undefined: stall on any EXE/MEM match as above; fwd inputs ignored.

Test Plan:
- rst=1 for 2 cycles then release, inst_valid=0 -> every output 0, stall_out=0, stall_cnt=0.
- WB writes r5=0x1234 in the same cycle ID reads an ADD with src1=5 -> next cycle reg1=0x1234; a write to r0 leaves reads of r0 at 0.
- Immediate op, imm=0x8000, SIGN_EXT=1 -> reg2=0xFFFF8000, out_dest=src2; SIGN_EXT=0 -> reg2=0x00008000.
- exe_dest=3, exe_wb_en=1, ID src1=3, no FORWARD_EN -> stall_out=1, bubble with valid_out=0, stall_cnt increments; clearing exe_wb_en -> instruction issues next cycle.
- Same hazard plus flush=1 -> stall_out=0, bubble registered, stall_cnt unchanged.
- FORWARD_EN, mem_dest=4, mem_wb_en=1, mem_fwd_value=0xAA, src2=4 R-type -> no stall, reg2=0xAA; exe_mem_read=1, exe_dest=4 -> one stall cycle.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage with built-in register file, ID/EXE pipeline register, RAW hazard stall and stall counter.
// Optional macro FORWARD_EN: forward EXE/MEM results and stall only on load-use.
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit SIGN_EXT   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [31:0]           inst_in,
    input  logic                  inst_valid,
    input  logic                  flush,
    input  logic                  wb_write_en,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    input  logic [XLEN-1:0]       wb_value,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  exe_wb_en,
    input  logic                  mem_wb_en,
    input  logic                  exe_mem_read,
    input  logic [XLEN-1:0]       exe_fwd_value,
    input  logic [XLEN-1:0]       mem_fwd_value,
    output logic                  stall_out,
    output logic                  valid_out,
    output logic [XLEN-1:0]       pc_out,
    output logic                  wb_en,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [1:0]            br,
    output logic [3:0]            exe_cmd,
    output logic [XLEN-1:0]       reg1,
    output logic [XLEN-1:0]       reg2,
    output logic [XLEN-1:0]       st_val,
    output logic [REG_ADDR_W-1:0] out_dest,
    output logic [31:0]           stall_cnt
);

    localparam int NREGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_ADD  = 6'd1;
    localparam logic [5:0] OP_SUB  = 6'd2;
    localparam logic [5:0] OP_AND  = 6'd3;
    localparam logic [5:0] OP_OR   = 6'd4;
    localparam logic [5:0] OP_NOR  = 6'd5;
    localparam logic [5:0] OP_XOR  = 6'd6;
    localparam logic [5:0] OP_SLA  = 6'd7;
    localparam logic [5:0] OP_SLL  = 6'd8;
    localparam logic [5:0] OP_SRA  = 6'd9;
    localparam logic [5:0] OP_SRL  = 6'd10;
    localparam logic [5:0] OP_ADDI = 6'd32;
    localparam logic [5:0] OP_SUBI = 6'd33;
    localparam logic [5:0] OP_LD   = 6'd36;
    localparam logic [5:0] OP_ST   = 6'd37;
    localparam logic [5:0] OP_BEZ  = 6'd40;
    localparam logic [5:0] OP_BNE  = 6'd41;
    localparam logic [5:0] OP_JMP  = 6'd42;

    logic [XLEN-1:0] rf [NREGS];

    logic [5:0]            opcode;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic [15:0]           imm16;
    logic [XLEN-1:0]       imm_ext;

    assign opcode  = inst_in[31:26];
    assign src1    = inst_in[21 +: REG_ADDR_W];
    assign src2    = inst_in[16 +: REG_ADDR_W];
    assign dest    = inst_in[11 +: REG_ADDR_W];
    assign imm16   = inst_in[15:0];
    assign imm_ext = SIGN_EXT ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};

    logic       dec_wb_en;
    logic       dec_mem_read;
    logic       dec_mem_write;
    logic       dec_is_imm;
    logic [1:0] dec_br;
    logic [3:0] dec_cmd;

    always_comb begin
        dec_wb_en     = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_is_imm    = 1'b0;
        dec_br        = 2'b00;
        dec_cmd       = 4'b0000;
        case (opcode)
            OP_ADD:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0001; end
            OP_SUB:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0010; end
            OP_AND:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0011; end
            OP_OR:   begin dec_wb_en = 1'b1; dec_cmd = 4'b0100; end
            OP_NOR:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0101; end
            OP_XOR:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0110; end
            OP_SLA:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0111; end
            OP_SLL:  begin dec_wb_en = 1'b1; dec_cmd = 4'b0111; end
            OP_SRA:  begin dec_wb_en = 1'b1; dec_cmd = 4'b1000; end
            OP_SRL:  begin dec_wb_en = 1'b1; dec_cmd = 4'b1001; end
            OP_ADDI: begin dec_wb_en = 1'b1; dec_is_imm = 1'b1; dec_cmd = 4'b0001; end
            OP_SUBI: begin dec_wb_en = 1'b1; dec_is_imm = 1'b1; dec_cmd = 4'b0010; end
            OP_LD: begin
                dec_wb_en    = 1'b1;
                dec_mem_read = 1'b1;
                dec_is_imm   = 1'b1;
                dec_cmd      = 4'b0001;
            end
            OP_ST: begin
                dec_mem_write = 1'b1;
                dec_is_imm    = 1'b1;
                dec_cmd       = 4'b0001;
            end
            OP_BEZ:  begin dec_is_imm = 1'b1; dec_br = 2'b01; end
            OP_BNE:  begin dec_is_imm = 1'b1; dec_br = 2'b10; end
            OP_JMP:  begin dec_is_imm = 1'b1; dec_br = 2'b11; end
            default: ;
        endcase
    end

    // Operand read: r0 is hardwired, later pipeline stages override the file contents
    function automatic logic [XLEN-1:0] read_reg(input logic [REG_ADDR_W-1:0] a);
        logic [XLEN-1:0] r;
        if (a == '0)
            r = '0;
`ifdef FORWARD_EN
        else if (exe_wb_en && exe_dest == a)
            r = exe_fwd_value;
        else if (mem_wb_en && mem_dest == a)
            r = mem_fwd_value;
`endif
        else if (wb_write_en && wb_dest == a)
            r = wb_value;
        else
            r = rf[a];
        return r;
    endfunction

    logic [XLEN-1:0] src1_val;
    logic [XLEN-1:0] src2_val;

    always_comb begin
        src1_val = read_reg(src1);
        src2_val = read_reg(src2);
    end

    logic use_src2;
    logic hit1;
    logic hit2;
    logic hazard;

    assign use_src2 = !dec_is_imm || dec_mem_write;

`ifdef FORWARD_EN
    assign hit1 = exe_mem_read && exe_wb_en && exe_dest == src1;
    assign hit2 = exe_mem_read && exe_wb_en && exe_dest == src2;
`else
    assign hit1 = (exe_wb_en && exe_dest == src1) || (mem_wb_en && mem_dest == src1);
    assign hit2 = (exe_wb_en && exe_dest == src2) || (mem_wb_en && mem_dest == src2);

    logic unused_fwd;
    assign unused_fwd = ^{exe_fwd_value, mem_fwd_value, exe_mem_read};
`endif

    assign hazard    = inst_valid && ((src1 != '0 && hit1) || (use_src2 && src2 != '0 && hit2));
    assign stall_out = hazard && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                rf[i] <= '0;
        end else if (wb_write_en && wb_dest != '0) begin
            rf[wb_dest] <= wb_value;
        end
    end

    // Flush and stall both insert a fully zeroed bubble
    always_ff @(posedge clk) begin
        if (rst || flush || stall_out) begin
            valid_out <= 1'b0;
            pc_out    <= '0;
            wb_en     <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            br        <= 2'b00;
            exe_cmd   <= 4'b0000;
            reg1      <= '0;
            reg2      <= '0;
            st_val    <= '0;
            out_dest  <= '0;
        end else begin
            valid_out <= inst_valid;
            pc_out    <= pc_in;
            wb_en     <= inst_valid && dec_wb_en;
            mem_read  <= inst_valid && dec_mem_read;
            mem_write <= inst_valid && dec_mem_write;
            br        <= inst_valid ? dec_br : 2'b00;
            exe_cmd   <= inst_valid ? dec_cmd : 4'b0000;
            reg1      <= src1_val;
            reg2      <= dec_is_imm ? imm_ext : src2_val;
            st_val    <= src2_val;
            out_dest  <= dec_is_imm ? src2 : dest;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_out && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Table-driven scoreboard bench for id_stage_pipe; hazard sequences follow the FORWARD_EN build setting.
module tb_id_stage_pipe;

    typedef struct {
        logic        rst;
        logic        valid;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wb_we;
        logic [4:0]  wb_dest;
        logic [31:0] wb_val;
        logic [4:0]  exe_dest;
        logic [4:0]  mem_dest;
        logic        exe_wb_en;
        logic        mem_wb_en;
        logic        exe_mem_read;
        logic [31:0] exe_fwd;
        logic [31:0] mem_fwd;
    } stim_t;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [31:0] pc;
        logic [8:0]  ctrl;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] reg2_zx;
        logic [31:0] st_val;
        logic [4:0]  dest;
        logic [31:0] cnt;
        logic        chk_data;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam logic [8:0] C_ADD = 9'b1_0_0_00_0001;
    localparam logic [8:0] C_SUB = 9'b1_0_0_00_0010;
    localparam logic [8:0] C_LD  = 9'b1_1_0_00_0001;
    localparam logic [8:0] C_ST  = 9'b0_0_1_00_0001;
    localparam logic [8:0] C_BEZ = 9'b0_0_0_01_0000;

    logic        clk;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] inst_in;
    logic        inst_valid;
    logic        flush;
    logic        wb_write_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_value;
    logic [4:0]  exe_dest;
    logic [4:0]  mem_dest;
    logic        exe_wb_en;
    logic        mem_wb_en;
    logic        exe_mem_read;
    logic [31:0] exe_fwd_value;
    logic [31:0] mem_fwd_value;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic        wb_en;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  br;
    logic [3:0]  exe_cmd;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [31:0] st_val;
    logic [4:0]  out_dest;
    logic [31:0] stall_cnt;

    logic [31:0] zx_reg2;
    logic        unused_zx_stall;
    logic        unused_zx_valid;
    logic [31:0] unused_zx_pc;
    logic        unused_zx_wb_en;
    logic        unused_zx_mem_read;
    logic        unused_zx_mem_write;
    logic [1:0]  unused_zx_br;
    logic [3:0]  unused_zx_cmd;
    logic [31:0] unused_zx_reg1;
    logic [31:0] unused_zx_st_val;
    logic [4:0]  unused_zx_dest;
    logic [31:0] unused_zx_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t exp_q[$];
    vec_t tbl[11];

    id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .SIGN_EXT(1'b1)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .inst_valid(inst_valid),
        .flush(flush), .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_read(exe_mem_read), .exe_fwd_value(exe_fwd_value), .mem_fwd_value(mem_fwd_value),
        .stall_out(stall_out), .valid_out(valid_out), .pc_out(pc_out), .wb_en(wb_en),
        .mem_read(mem_read), .mem_write(mem_write), .br(br), .exe_cmd(exe_cmd), .reg1(reg1),
        .reg2(reg2), .st_val(st_val), .out_dest(out_dest), .stall_cnt(stall_cnt)
    );

    id_stage_pipe #(.XLEN(32), .REG_ADDR_W(5), .SIGN_EXT(1'b0)) dut_zx (
        .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .inst_valid(inst_valid),
        .flush(flush), .wb_write_en(wb_write_en), .wb_dest(wb_dest), .wb_value(wb_value),
        .exe_dest(exe_dest), .mem_dest(mem_dest), .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_mem_read(exe_mem_read), .exe_fwd_value(exe_fwd_value), .mem_fwd_value(mem_fwd_value),
        .stall_out(unused_zx_stall), .valid_out(unused_zx_valid), .pc_out(unused_zx_pc),
        .wb_en(unused_zx_wb_en), .mem_read(unused_zx_mem_read), .mem_write(unused_zx_mem_write),
        .br(unused_zx_br), .exe_cmd(unused_zx_cmd), .reg1(unused_zx_reg1), .reg2(zx_reg2),
        .st_val(unused_zx_st_val), .out_dest(unused_zx_dest), .stall_cnt(unused_zx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [4:0] d);
        return {op, s1, s2, d, 11'd0};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [15:0] imm);
        return {op, s1, s2, imm};
    endfunction

    function automatic stim_t st0(input logic [31:0] pc, input logic [31:0] inst);
        stim_t s;
        s.rst = 1'b0; s.valid = 1'b1; s.flush = 1'b0; s.pc = pc; s.inst = inst;
        s.wb_we = 1'b0; s.wb_dest = 5'd0; s.wb_val = 32'd0;
        s.exe_dest = 5'd0; s.mem_dest = 5'd0; s.exe_wb_en = 1'b0; s.mem_wb_en = 1'b0;
        s.exe_mem_read = 1'b0; s.exe_fwd = 32'd0; s.mem_fwd = 32'd0;
        return s;
    endfunction

    function automatic exp_t ex_bubble(input logic stall, input logic [31:0] cnt);
        exp_t e;
        e.stall = stall; e.valid = 1'b0; e.pc = 32'd0; e.ctrl = 9'd0;
        e.reg1 = 32'd0; e.reg2 = 32'd0; e.reg2_zx = 32'd0; e.st_val = 32'd0;
        e.dest = 5'd0; e.cnt = cnt; e.chk_data = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_issue(input logic [31:0] pc, input logic [8:0] ctrl, input logic [31:0] r1,
                                      input logic [31:0] r2, input logic [31:0] r2zx, input logic [31:0] sv,
                                      input logic [4:0] d, input logic [31:0] cnt);
        exp_t e;
        e.stall = 1'b0; e.valid = 1'b1; e.pc = pc; e.ctrl = ctrl;
        e.reg1 = r1; e.reg2 = r2; e.reg2_zx = r2zx; e.st_val = sv;
        e.dest = d; e.cnt = cnt; e.chk_data = 1'b1;
        return e;
    endfunction

    task automatic compareField(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic applyStimulus(input stim_t s, input exp_t e);
        rst           = s.rst;
        inst_valid    = s.valid;
        flush         = s.flush;
        pc_in         = s.pc;
        inst_in       = s.inst;
        wb_write_en   = s.wb_we;
        wb_dest       = s.wb_dest;
        wb_value      = s.wb_val;
        exe_dest      = s.exe_dest;
        mem_dest      = s.mem_dest;
        exe_wb_en     = s.exe_wb_en;
        mem_wb_en     = s.mem_wb_en;
        exe_mem_read  = s.exe_mem_read;
        exe_fwd_value = s.exe_fwd;
        mem_fwd_value = s.mem_fwd;
        #1;
        compareField("stall_out", {31'd0, stall_out}, {31'd0, e.stall});
        exp_q.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        compareField("valid_out", {31'd0, valid_out}, {31'd0, e.valid});
        compareField("ctrl", {23'd0, wb_en, mem_read, mem_write, br, exe_cmd}, {23'd0, e.ctrl});
        compareField("stall_cnt", stall_cnt, e.cnt);
        if (e.chk_data) begin
            compareField("pc_out", pc_out, e.pc);
            compareField("reg1", reg1, e.reg1);
            compareField("reg2", reg2, e.reg2);
            compareField("reg2_zeroext", zx_reg2, e.reg2_zx);
            compareField("st_val", st_val, e.st_val);
            compareField("out_dest", {27'd0, out_dest}, {27'd0, e.dest});
        end
    endtask

    task automatic runVec(input stim_t s, input exp_t e);
        applyStimulus(s, e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        stim_t s;

        // Decode table: register file builds up across entries, no EXE/MEM hazards
        tbl[0].s = st0(32'h0, 32'h0); tbl[0].s.valid = 1'b0;
        tbl[0].e = ex_bubble(1'b0, 0);
        tbl[1].s = st0(32'h100, rtype(6'd1, 5'd5, 5'd6, 5'd7));
        tbl[1].s.wb_we = 1'b1; tbl[1].s.wb_dest = 5'd5; tbl[1].s.wb_val = 32'h1234;
        tbl[1].e = ex_issue(32'h100, C_ADD, 32'h1234, 0, 0, 0, 5'd7, 0);
        tbl[2].s = st0(32'h104, rtype(6'd2, 5'd0, 5'd5, 5'd8));
        tbl[2].s.wb_we = 1'b1; tbl[2].s.wb_dest = 5'd0; tbl[2].s.wb_val = 32'hDEAD;
        tbl[2].e = ex_issue(32'h104, C_SUB, 0, 32'h1234, 32'h1234, 32'h1234, 5'd8, 0);
        tbl[3].s = st0(32'h108, rtype(6'd2, 5'd0, 5'd6, 5'd9));
        tbl[3].s.wb_we = 1'b1; tbl[3].s.wb_dest = 5'd6; tbl[3].s.wb_val = 32'hCAFE;
        tbl[3].e = ex_issue(32'h108, C_SUB, 0, 32'hCAFE, 32'hCAFE, 32'hCAFE, 5'd9, 0);
        tbl[4].s = st0(32'h10C, itype(6'd32, 5'd5, 5'd9, 16'h8000));
        tbl[4].e = ex_issue(32'h10C, C_ADD, 32'h1234, 32'hFFFF8000, 32'h00008000, 0, 5'd9, 0);
        tbl[5].s = st0(32'h110, itype(6'd36, 5'd6, 5'd10, 16'h0010));
        tbl[5].e = ex_issue(32'h110, C_LD, 32'hCAFE, 32'h10, 32'h10, 0, 5'd10, 0);
        tbl[6].s = st0(32'h114, itype(6'd37, 5'd5, 5'd6, 16'h7FFF));
        tbl[6].e = ex_issue(32'h114, C_ST, 32'h1234, 32'h7FFF, 32'h7FFF, 32'hCAFE, 5'd6, 0);
        tbl[7].s = st0(32'h118, itype(6'd40, 5'd5, 5'd0, 16'hFFFE));
        tbl[7].e = ex_issue(32'h118, C_BEZ, 32'h1234, 32'hFFFFFFFE, 32'h0000FFFE, 0, 5'd0, 0);
        tbl[8].s = st0(32'h11C, rtype(6'd1, 5'd5, 5'd6, 5'd7)); tbl[8].s.flush = 1'b1;
        tbl[8].e = ex_bubble(1'b0, 0);
        tbl[9].s = st0(32'h120, rtype(6'd1, 5'd0, 5'd0, 5'd13));
        tbl[9].s.exe_wb_en = 1'b1; tbl[9].s.mem_wb_en = 1'b1;
        tbl[9].e = ex_issue(32'h120, C_ADD, 0, 0, 0, 0, 5'd13, 0);
        tbl[10].s = st0(32'h124, rtype(6'd1, 5'd5, 5'd6, 5'd7)); tbl[10].s.valid = 1'b0;
        tbl[10].s.exe_dest = 5'd5; tbl[10].s.exe_wb_en = 1'b1; tbl[10].s.exe_mem_read = 1'b1;
        tbl[10].e = ex_bubble(1'b0, 0); tbl[10].e.chk_data = 1'b0;

        s = st0(32'h0, 32'h0);
        s.valid = 1'b0;
        s.rst = 1'b1;
        rst = 1'b1; inst_valid = 1'b0; flush = 1'b0; pc_in = '0; inst_in = '0;
        wb_write_en = 1'b0; wb_dest = '0; wb_value = '0; exe_dest = '0; mem_dest = '0;
        exe_wb_en = 1'b0; mem_wb_en = 1'b0; exe_mem_read = 1'b0; exe_fwd_value = '0; mem_fwd_value = '0;
        repeat (2) @(posedge clk);
        #1;
        s.rst = 1'b0;
        applyStimulus(s, ex_bubble(1'b0, 0));
        checkOutput();
        $display("[TB] reset state checked");

        for (int i = 0; i < 11; i++)
            runVec(tbl[i].s, tbl[i].e);

`ifdef FORWARD_EN
        s = st0(32'h300, rtype(6'd1, 5'd0, 5'd4, 5'd12));
        s.mem_dest = 5'd4; s.mem_wb_en = 1'b1; s.mem_fwd = 32'hAA;
        runVec(s, ex_issue(32'h300, C_ADD, 0, 32'hAA, 32'hAA, 32'hAA, 5'd12, 0));
        s = st0(32'h304, rtype(6'd1, 5'd4, 5'd0, 5'd13));
        s.exe_dest = 5'd4; s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.exe_fwd = 32'h99;
        runVec(s, ex_bubble(1'b1, 1));
        s.exe_mem_read = 1'b0; s.exe_fwd = 32'hBB;
        s.mem_dest = 5'd4; s.mem_wb_en = 1'b1; s.mem_fwd = 32'hAA;
        runVec(s, ex_issue(32'h304, C_ADD, 32'hBB, 0, 0, 0, 5'd13, 1));
        s = st0(32'h308, rtype(6'd1, 5'd5, 5'd5, 5'd14));
        s.mem_dest = 5'd5; s.mem_wb_en = 1'b1; s.mem_fwd = 32'hCC;
        s.wb_we = 1'b1; s.wb_dest = 5'd5; s.wb_val = 32'h55;
        runVec(s, ex_issue(32'h308, C_ADD, 32'hCC, 32'hCC, 32'hCC, 32'hCC, 5'd14, 1));
        s = st0(32'h30C, rtype(6'd1, 5'd5, 5'd6, 5'd15));
        s.wb_we = 1'b1; s.wb_dest = 5'd6; s.wb_val = 32'h66;
        runVec(s, ex_issue(32'h30C, C_ADD, 32'h55, 32'h66, 32'h66, 32'h66, 5'd15, 1));
        s = st0(32'h310, itype(6'd37, 5'd5, 5'd6, 16'h0));
        s.exe_dest = 5'd6; s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.flush = 1'b1;
        runVec(s, ex_bubble(1'b0, 1));
        s = st0(32'h314, rtype(6'd1, 5'd6, 5'd0, 5'd9));
        s.exe_dest = 5'd6; s.exe_wb_en = 1'b1; s.exe_mem_read = 1'b1; s.rst = 1'b1;
        runVec(s, ex_bubble(1'b1, 0));
`else
        s = st0(32'h200, rtype(6'd1, 5'd3, 5'd1, 5'd11));
        s.exe_dest = 5'd3; s.exe_wb_en = 1'b1;
        runVec(s, ex_bubble(1'b1, 1));
        runVec(s, ex_bubble(1'b1, 2));
        s.exe_wb_en = 1'b0; s.wb_we = 1'b1; s.wb_dest = 5'd3; s.wb_val = 32'h33;
        runVec(s, ex_issue(32'h200, C_ADD, 32'h33, 0, 0, 0, 5'd11, 2));
        s = st0(32'h204, rtype(6'd1, 5'd5, 5'd6, 5'd12));
        s.mem_dest = 5'd6; s.mem_wb_en = 1'b1;
        runVec(s, ex_bubble(1'b1, 3));
        s.flush = 1'b1;
        runVec(s, ex_bubble(1'b0, 3));
        s = st0(32'h208, itype(6'd32, 5'd5, 5'd6, 16'h0004));
        s.mem_dest = 5'd6; s.mem_wb_en = 1'b1;
        runVec(s, ex_issue(32'h208, C_ADD, 32'h1234, 32'h4, 32'h4, 32'hCAFE, 5'd6, 3));
        s = st0(32'h20C, itype(6'd37, 5'd5, 5'd6, 16'h0004));
        s.mem_dest = 5'd6; s.mem_wb_en = 1'b1;
        runVec(s, ex_bubble(1'b1, 4));
        s = st0(32'h210, rtype(6'd1, 5'd7, 5'd3, 5'd14));
        s.exe_dest = 5'd7; s.exe_wb_en = 1'b1; s.rst = 1'b1;
        runVec(s, ex_bubble(1'b1, 0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
